// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even and flush-to-zero.
// States: IDLE wait | UNPACK specials/order | ALIGN shift B | ADD | NORM | ROUND.
module fp_addsub_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] y,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SW     = MAN_W + 5;
    localparam int MAX_SH = MAN_W + 3;
    localparam int CW     = $clog2(MAX_SH + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W:0]   EXP_INC  = (EXP_W+1)'(1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

    state_t           state, state_n;
    logic [W-1:0]     xr, xr_n, yr, yr_n, result_n;
    logic             opr, opr_n, sign_a, sign_a_n, sign_b, sign_b_n;
    logic [EXP_W:0]   exp_r, exp_n;
    logic [SW-1:0]    sig_a, sig_a_n, sig_b, sig_b_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             done_n, ovf_n, unf_n, inv_n;

    logic             sx, sy, nan_x, nan_y, inf_x, inf_y, zero_x, zero_y, special, x_big;
    logic [EXP_W-1:0] ex, ey, ediff;
    logic [MAN_W-1:0] fx, fy;
    logic [SW-1:0]    sig_x, sig_y, sum;
    logic             round_up;
    logic [MAN_W+1:0] mant;
    logic [EXP_W:0]   exp_rnd;
    logic [MAN_W-1:0] frac_rnd;

    // Operand fields; op is folded into y's sign here.
    assign sx      = xr[W-1];
    assign sy      = yr[W-1] ^ opr;
    assign ex      = xr[W-2:MAN_W];
    assign ey      = yr[W-2:MAN_W];
    assign fx      = xr[MAN_W-1:0];
    assign fy      = yr[MAN_W-1:0];
    assign nan_x   = (ex == EXP_ONES) && (fx != '0);
    assign nan_y   = (ey == EXP_ONES) && (fy != '0);
    assign inf_x   = (ex == EXP_ONES) && (fx == '0);
    assign inf_y   = (ey == EXP_ONES) && (fy == '0);
    assign zero_x  = (ex == '0);
    assign zero_y  = (ey == '0);
    assign special = nan_x | nan_y | inf_x | inf_y | zero_x | zero_y;
    assign x_big   = xr[W-2:0] >= yr[W-2:0];
    assign ediff   = x_big ? (ex - ey) : (ey - ex);
    assign sig_x   = {2'b01, fx, 3'b000};
    assign sig_y   = {2'b01, fy, 3'b000};

    assign sum      = (sign_a == sign_b) ? (sig_a + sig_b) : (sig_a - sig_b);
    assign round_up = sig_a[2] & (sig_a[1] | sig_a[0] | sig_a[3]);
    assign mant     = {1'b0, sig_a[SW-2:3]} + (MAN_W+2)'(round_up);
    assign exp_rnd  = exp_r + (EXP_W+1)'(mant[MAN_W+1]);
    assign frac_rnd = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

    assign busy = (state != S_IDLE);

    always_comb begin
        state_n  = state;
        xr_n     = xr;
        yr_n     = yr;
        opr_n    = opr;
        sign_a_n = sign_a;
        sign_b_n = sign_b;
        exp_n    = exp_r;
        sig_a_n  = sig_a;
        sig_b_n  = sig_b;
        cnt_n    = cnt;
        result_n = result;
        ovf_n    = overflow;
        unf_n    = underflow;
        inv_n    = invalid;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    xr_n    = x;
                    yr_n    = y;
                    opr_n   = op;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                    inv_n   = 1'b0;
                    state_n = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (special) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                    if (nan_x || nan_y || (inf_x && inf_y && (sx != sy))) begin
                        result_n = QNAN;
                        inv_n    = 1'b1;
                    end else if (inf_x)
                        result_n = xr;
                    else if (inf_y)
                        result_n = {sy, yr[W-2:0]};
                    else if (zero_x && zero_y)
                        result_n = {sx & sy, {(W-1){1'b0}}};
                    else if (zero_x)
                        result_n = {sy, yr[W-2:0]};
                    else
                        result_n = xr;
                end else begin
                    sign_a_n = x_big ? sx : sy;
                    sign_b_n = x_big ? sy : sx;
                    exp_n    = {1'b0, x_big ? ex : ey};
                    sig_a_n  = x_big ? sig_x : sig_y;
                    sig_b_n  = x_big ? sig_y : sig_x;
                    cnt_n    = (int'(ediff) > MAX_SH) ? CW'(MAX_SH) : CW'(ediff);
                    state_n  = (ediff == '0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                sig_b_n = {1'b0, sig_b[SW-1:2], sig_b[1] | sig_b[0]};
                cnt_n   = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_n = S_ADD;
            end
            S_ADD: begin
                if (sum == '0) begin
                    result_n = '0;
                    done_n   = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    sig_a_n = sum;
                    state_n = (sum[SW-1] || !sum[SW-2]) ? S_NORM : S_ROUND;
                end
            end
            S_NORM: begin
                if (sig_a[SW-1]) begin
                    sig_a_n = {1'b0, sig_a[SW-1:2], sig_a[1] | sig_a[0]};
                    exp_n   = exp_r + EXP_INC;
                    state_n = S_ROUND;
                end else if (exp_r == EXP_INC) begin
                    // Another left shift would need exponent 0: the result is subnormal.
                    result_n = {sign_a, {(W-1){1'b0}}};
                    unf_n    = 1'b1;
                    done_n   = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    sig_a_n = {sig_a[SW-2:0], 1'b0};
                    exp_n   = exp_r - EXP_INC;
                    if (sig_a[SW-3])
                        state_n = S_ROUND;
                end
            end
            S_ROUND: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
                if (exp_rnd >= {1'b0, EXP_ONES}) begin
                    result_n = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
                    ovf_n    = 1'b1;
                end else
                    result_n = {sign_a, exp_rnd[EXP_W-1:0], frac_rnd};
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr        <= '0;
            yr        <= '0;
            opr       <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            exp_r     <= '0;
            sig_a     <= '0;
            sig_b     <= '0;
            cnt       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            done      <= 1'b0;
        end else begin
            xr        <= xr_n;
            yr        <= yr_n;
            opr       <= opr_n;
            sign_a    <= sign_a_n;
            sign_b    <= sign_b_n;
            exp_r     <= exp_n;
            sig_a     <= sig_a_n;
            sig_b     <= sig_b_n;
            cnt       <= cnt_n;
            result    <= result_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
            invalid   <= inv_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq (binary16): directed table, random traffic, reset and handshake cases.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [15:0] x, y, result;
    logic        busy, done, overflow, underflow, invalid;

    always #5 clk = ~clk;

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    typedef struct {
        logic [15:0] res;
        logic        ov, un, inv;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mon_lat;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact sum of the two values as an integer multiple of 2^-24, then RNE.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic o);
        exp_t   r;
        logic   sa, sb, sg;
        int     ea, eb, fa, fb, p, e, sh;
        longint va, vb, s, mag, q, rem, half;
        logic   nan_a, nan_b, inf_a, inf_b;
        r.res = 16'h0; r.ov = 0; r.un = 0; r.inv = 0; r.acc = 0; r.lat = 2;
        sa = a[15]; sb = b[15] ^ o;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        nan_a = (ea == 31) && (fa != 0); inf_a = (ea == 31) && (fa == 0);
        nan_b = (eb == 31) && (fb != 0); inf_b = (eb == 31) && (fb == 0);
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
            r.res = 16'h7E00; r.inv = 1;
        end else if (inf_a) r.res = a;
        else if (inf_b) r.res = {sb, 5'h1F, 10'h0};
        else if (ea == 0 && eb == 0) r.res = {sa & sb, 15'h0};
        else if (ea == 0) r.res = {sb, b[14:0]};
        else if (eb == 0) r.res = a;
        else begin
            r.lat = 0;
            va = longint'(1024 + fa) << (ea - 1);
            vb = longint'(1024 + fb) << (eb - 1);
            s = (sa ? -va : va) + (sb ? -vb : vb);
            if (s != 0) begin
                sg = (s < 0);
                mag = sg ? -s : s;
                p = 0;
                for (int i = 0; i < 63; i++) if (mag[i]) p = i;
                e = p - 9;
                if (e < 1) begin
                    r.res = {sg, 15'h0}; r.un = 1;
                end else begin
                    q = mag;
                    if (p > 10) begin
                        sh = p - 10;
                        q = mag >> sh;
                        rem = mag - (q << sh);
                        half = longint'(1) << (sh - 1);
                        if (rem > half || (rem == half && q[0])) q = q + 1;
                    end
                    if (q == 2048) begin q = 1024; e = e + 1; end
                    if (e >= 31) begin
                        r.res = {sg, 5'h1F, 10'h0}; r.ov = 1;
                    end else r.res = {sg, 5'(e), 10'(q)};
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd_op(input int near);
        int          cls, e;
        logic [9:0]  f;
        cls = int'($urandom_range(0, 11));
        f = 10'($urandom);
        if (cls == 0) e = 0;
        else if (cls == 1) begin
            e = 31;
            if ($urandom_range(0, 1) == 0) f = 10'h0;
        end else if (near >= 1 && near <= 30 && cls > 5) begin
            e = near + int'($urandom_range(0, 4)) - 2;
            if (e < 1) e = 1;
            if (e > 30) e = 30;
        end else e = int'($urandom_range(1, 30));
        return {1'($urandom), 5'(e), f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("idle_wait_bound", 32'(busy), 32'd0);
    endtask

    task automatic issue_exp(input logic [15:0] a, input logic [15:0] b, input logic o, input exp_t e);
        @(negedge clk);
        wait_idle();
        e.acc = cyc + 1;
        sbq.push_back(e);
        start = 1'b1; x = a; y = b; op = o;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic o);
        issue_exp(a, b, o, model(a, b, o));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=%h with nothing pending", result);
            end else begin
                mon_e = sbq.pop_front();
                mon_lat = cyc - mon_e.acc + 1;
                if ({result, overflow, underflow, invalid} !== {mon_e.res, mon_e.ov, mon_e.un, mon_e.inv}) begin
                    errors++;
                    $display("FAIL result_flags: got %h ov%b un%b inv%b expected %h ov%b un%b inv%b",
                             result, overflow, underflow, invalid, mon_e.res, mon_e.ov, mon_e.un, mon_e.inv);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b expected 0", busy);
                end
                checks++;
                if ((mon_e.lat > 0) ? (mon_lat != mon_e.lat) : (mon_lat < 3 || mon_lat > 31)) begin
                    errors++;
                    $display("FAIL latency: got %0d expected %0d (0 = within 3..31)", mon_lat, mon_e.lat);
                end
            end
        end
    end

    localparam int ND = 15;
    logic [15:0] tx   [ND] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h8000, 16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF,
                               16'h7C00, 16'h0401, 16'h0400, 16'h7E01, 16'hFC00, 16'h4000, 16'hC000};
    logic [15:0] ty   [ND] = '{16'h4000, 16'h3C00, 16'h0000, 16'h0000, 16'h1000, 16'h1200, 16'h1000, 16'h7BFF,
                               16'h7C00, 16'h0400, 16'h03FF, 16'h3C00, 16'h4000, 16'hC000, 16'h4000};
    logic        top  [ND] = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
    logic [15:0] tres [ND] = '{16'h4200, 16'h0000, 16'h0000, 16'h8000, 16'h3C00, 16'h3C01, 16'h3C02, 16'h7C00,
                               16'h7E00, 16'h0000, 16'h0400, 16'h7E00, 16'hFC00, 16'h4400, 16'h0000};
    logic [2:0]  tflg [ND] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                               3'b001, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    int          tlat [ND] = '{5, 0, 2, 2, 0, 0, 0, 0, 2, 0, 2, 2, 2, 5, 0};

    initial begin
        exp_t        e;
        logic [15:0] a, b;
        reset = 1'b1; start = 1'b0; op = 1'b0; x = 16'h0; y = 16'h0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({overflow, underflow, invalid}), 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < ND; i++) begin
            e.res = tres[i]; {e.ov, e.un, e.inv} = tflg[i]; e.lat = tlat[i]; e.acc = 0;
            issue_exp(tx[i], ty[i], top[i], e);
        end

        for (int i = 0; i < 400; i++) begin
            a = rnd_op(0);
            b = ($urandom_range(0, 7) == 0) ? a : rnd_op(int'(a[14:10]));
            issue(a, b, 1'($urandom));
        end
        drain();

        // Abort mid-alignment: no done may follow and every output clears at once.
        @(negedge clk);
        start = 1'b1; x = 16'h3C00; y = 16'h1000; op = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_flags", 32'({overflow, underflow, invalid}), 32'd0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_after_abort", 32'(busy), 32'd0);

        // start held while busy must not capture new operands
        issue(16'h3C00, 16'h1000, 1'b0);
        @(negedge clk);
        start = 1'b1; x = 16'h7BFF; y = 16'h7BFF; op = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 0) ? 16'h0000 : 16'h7C00;
            issue(a, rnd_op(0), 1'(i / 2));
        end
        drain();
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
